// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, ALU operations
// and the control bundle that travels from decode into execute.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    // ALU_PASSB feeds the immediate straight through (LUI); ALU_ADDPC adds
    // the immediate to the PC (AUIPC).
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_ADDPC = 4'd11
    } alu_ctrl_e;

    // result_src = 1 selects load data; jumps write PC+4, chosen in execute
    // from the jump bit.
    typedef struct packed {
        logic      reg_write;
        logic      alu_src;
        logic      mem_write;
        logic      mem_read;
        logic      result_src;
        logic      branch;
        logic      jump;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Base ALU operation from funct3 for OP/OP-IMM; the SUB/SRA variants are
    // selected separately from funct7.
    function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder: control bundle, immediate format,
// source-register usage and the illegal-instruction flag.
module decode_ctrl
    import rv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output imm_src_e    imm_src,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    ctrl_t      c;
    logic       bad;

    assign op  = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign f7  = instr[31:25];

    // Decode by opcode, then reject bad funct fields and register indices
    // outside the implemented file (RV32E).
    always_comb begin
        c        = CTRL_BUBBLE;
        imm_src  = IMM_I;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        bad      = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = (op == OP_LUI) ? ALU_PASSB : ALU_ADDPC;
                imm_src     = IMM_U;
                uses_rs1    = 1'b0;
            end
            OP_JAL: begin
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
                imm_src     = IMM_J;
                uses_rs1    = 1'b0;
            end
            OP_JALR: begin
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
                c.alu_src   = 1'b1;
                bad         = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                c.branch = 1'b1;
                imm_src  = IMM_B;
                uses_rs2 = 1'b1;
                case (f3)
                    3'b000, 3'b001: c.alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: c.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: c.alu_ctrl = ALU_SLTU;
                    default:        bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.result_src = 1'b1;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                imm_src     = IMM_S;
                uses_rs2    = 1'b1;
                bad         = (f3 > 3'b010);
            end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = alu_from_f3(f3);
                if (f3 == 3'b001) begin
                    bad = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    if (f7[5]) c.alu_ctrl = ALU_SRA;
                end
            end
            OP_REG: begin
                c.reg_write = 1'b1;
                uses_rs2    = 1'b1;
                if (f7 == 7'b0000000) begin
                    c.alu_ctrl = alu_from_f3(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    c.alu_ctrl = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    c.alu_ctrl = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            default: begin
                bad      = 1'b1;
                uses_rs1 = 1'b0;
            end
        endcase
        if (uses_rs1 && int'(rs1) >= NREGS) bad = 1'b1;
        if (uses_rs2 && int'(rs2) >= NREGS) bad = 1'b1;
        if (c.reg_write && int'(rd) >= NREGS) bad = 1'b1;
    end

    assign illegal = bad;
    assign ctrl    = bad ? CTRL_BUBBLE : c;

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode stage and ID/EX register: register file with optional write-back
// bypass, immediate extension, load-use detection, and the E-stage register
// with flush/stall/bubble handling.
module decode_pipe_stage
    import rv_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter int               NREGS     = 32,
    parameter int               BYPASS_WB = 1,
    parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidD,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            LoadUseStall,
    output logic            ValidE,
    output logic            IllegalE,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            MemReadE,
    output logic            ResultSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [3:0]      ALUControlE,
    output logic [2:0]      funct3_E,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [4:0]      rs1, rs2, rd;
    ctrl_t           ctrl_d, ctrl_e;
    imm_src_e        imm_src;
    logic            uses_rs1, uses_rs2, illegal_d;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext, rd1, rd2;
    logic [XLEN-1:0] regs [NREGS];
    logic            wb_en, take;

    assign rs1 = InstrD[19:15];
    assign rs2 = InstrD[24:20];
    assign rd  = InstrD[11:7];

    decode_ctrl #(.NREGS(NREGS)) u_ctrl (
        .instr    (InstrD),
        .ctrl     (ctrl_d),
        .imm_src  (imm_src),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .illegal  (illegal_d)
    );

    // Writes to x0 or to indices beyond the implemented file are dropped.
    assign wb_en = RegWriteW && (RDW != 5'd0) && (int'(RDW) < NREGS);

    // Register file storage; cleared by reset alongside the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[RDW[IW-1:0]] <= ResultW;
        end
    end

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        rf_read = '0;
        if (idx != 5'd0 && int'(idx) < NREGS) begin
            if (BYPASS_WB != 0 && wb_en && RDW == idx) rf_read = ResultW;
            else                                       rf_read = regs[idx[IW-1:0]];
        end
    endfunction

    assign rd1 = rf_read(rs1);
    assign rd2 = rf_read(rs2);

    // Assemble the 32-bit immediate for the decoded format.
    always_comb begin
        imm32 = '0;
        case (imm_src)
            IMM_I:   imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                              InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_U:   imm32 = {InstrD[31:12], 12'b0};
            IMM_J:   imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                              InstrD[20], InstrD[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext = XLEN'($signed(imm32));

    assign LoadUseStall = ValidE && MemReadE && (RD_E != 5'd0) && ValidD &&
                          ((uses_rs1 && rs1 == RD_E) || (uses_rs2 && rs2 == RD_E));

    assign take = !FlushE && !LoadUseStall && ValidD;

    // ID/EX register: reset, then flush over stall, then bubble or load.
    // Bubbles still carry the D-stage PCs so traces stay readable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidE    <= 1'b0;
            IllegalE  <= 1'b0;
            ctrl_e    <= CTRL_BUBBLE;
            funct3_E  <= '0;
            RD1_E     <= '0;
            RD2_E     <= '0;
            Imm_Ext_E <= '0;
            RS1_E     <= '0;
            RS2_E     <= '0;
            RD_E      <= '0;
            PCE       <= RESET_PC;
            PCPlus4E  <= RESET_PC + XLEN'(4);
        end else if (FlushE || !StallE) begin
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            if (take) begin
                ValidE    <= 1'b1;
                IllegalE  <= illegal_d;
                ctrl_e    <= ctrl_d;
                funct3_E  <= InstrD[14:12];
                RD1_E     <= rd1;
                RD2_E     <= rd2;
                Imm_Ext_E <= imm_ext;
                RS1_E     <= rs1;
                RS2_E     <= rs2;
                RD_E      <= rd;
            end else begin
                ValidE    <= 1'b0;
                IllegalE  <= 1'b0;
                ctrl_e    <= CTRL_BUBBLE;
                funct3_E  <= '0;
                RD1_E     <= '0;
                RD2_E     <= '0;
                Imm_Ext_E <= '0;
                RS1_E     <= '0;
                RS2_E     <= '0;
                RD_E      <= '0;
            end
        end
    end

    assign RegWriteE   = ctrl_e.reg_write;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign MemWriteE   = ctrl_e.mem_write;
    assign MemReadE    = ctrl_e.mem_read;
    assign ResultSrcE  = ctrl_e.result_src;
    assign BranchE     = ctrl_e.branch;
    assign JumpE       = ctrl_e.jump;
    assign ALUControlE = ctrl_e.alu_ctrl;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage. Three instances share one stimulus:
// u=0 default (bypass on, RV32I), u=1 bypass off, u=2 RV32E. Expected E-stage
// values are queued when an instruction is driven and checked after the edge.
module tb_decode_pipe_stage;

    localparam int XLEN = 32;

    typedef enum int {
        S_VALID, S_ILL, S_REGW, S_ALUSRC, S_MEMW, S_MEMR, S_CTRL,
        S_RD1, S_RD2, S_IMM, S_PCE, S_PC4, S_RS1, S_RDE
    } sig_e;

    typedef struct {
        string       tag;
        int          u;
        sig_e        s;
        logic [31:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst, ValidD, StallE, FlushE, RegWriteW;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic [4:0]  RDW;

    logic        lus[3], vld[3], ill[3], regw[3], alusrc[3], memw[3], memr[3];
    logic        ressrc[3], br[3], jmp[3];
    logic [3:0]  aluc[3];
    logic [2:0]  f3[3];
    logic [31:0] rd1[3], rd2[3], imm[3], pce[3], pc4[3];
    logic [4:0]  rs1[3], rs2[3], rde[3];

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        decode_pipe_stage #(
            .XLEN      (XLEN),
            .NREGS     ((g == 2) ? 16 : 32),
            .BYPASS_WB ((g == 1) ? 0 : 1),
            .RESET_PC  (32'h8000_0000)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .ValidD       (ValidD),
            .InstrD       (InstrD),
            .PCD          (PCD),
            .PCPlus4D     (PCPlus4D),
            .StallE       (StallE),
            .FlushE       (FlushE),
            .RegWriteW    (RegWriteW),
            .RDW          (RDW),
            .ResultW      (ResultW),
            .LoadUseStall (lus[g]),
            .ValidE       (vld[g]),
            .IllegalE     (ill[g]),
            .RegWriteE    (regw[g]),
            .ALUSrcE      (alusrc[g]),
            .MemWriteE    (memw[g]),
            .MemReadE     (memr[g]),
            .ResultSrcE   (ressrc[g]),
            .BranchE      (br[g]),
            .JumpE        (jmp[g]),
            .ALUControlE  (aluc[g]),
            .funct3_E     (f3[g]),
            .RD1_E        (rd1[g]),
            .RD2_E        (rd2[g]),
            .Imm_Ext_E    (imm[g]),
            .PCE          (pce[g]),
            .PCPlus4E     (pc4[g]),
            .RS1_E        (rs1[g]),
            .RS2_E        (rs2[g]),
            .RD_E         (rde[g])
        );
    end

    function automatic logic [31:0] obs(input int u, input sig_e s);
        case (s)
            S_VALID:  return 32'(vld[u]);
            S_ILL:    return 32'(ill[u]);
            S_REGW:   return 32'(regw[u]);
            S_ALUSRC: return 32'(alusrc[u]);
            S_MEMW:   return 32'(memw[u]);
            S_MEMR:   return 32'(memr[u]);
            S_CTRL:   return 32'({regw[u], alusrc[u], memw[u], memr[u], ressrc[u],
                                  br[u], jmp[u], aluc[u]});
            S_RD1:    return rd1[u];
            S_RD2:    return rd2[u];
            S_IMM:    return imm[u];
            S_PCE:    return pce[u];
            S_PC4:    return pc4[u];
            S_RS1:    return 32'(rs1[u]);
            default:  return 32'(rde[u]);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, o, e);
        end
    endtask

    task automatic expect_e(input string tag, input int u, input sig_e s, input logic [31:0] v);
        exp_t x;
        x.tag = tag; x.u = u; x.s = s; x.v = v;
        q.push_back(x);
    endtask

    // Advance one edge, then retire every expectation queued before it.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            x = q.pop_front();
            chk($sformatf("%s[u%0d]", x.tag, x.u), obs(x.u, x.s), x.v);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        ValidD = v; InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        RegWriteW = en; RDW = r; ResultW = d;
    endtask

    localparam logic [31:0] I_LW_X5   = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_ADD_X6  = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] I_ADDI_X4 = 32'h00118213; // addi x4,x3,1
    localparam logic [31:0] I_ADD_X17 = 32'h002088B3; // add  x17,x1,x2
    localparam logic [31:0] I_ADD_X0  = 32'h000000B3; // add  x1,x0,x0
    localparam logic [31:0] I_SW      = 32'hFE20AE23; // sw   x2,-4(x1)
    localparam logic [31:0] I_ADD_X4  = 32'h00220333; // add  x6,x4,x2

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        expect_e("rst_pce", 0, S_PCE, 32'h8000_0000);
        expect_e("rst_pc4", 0, S_PC4, 32'h8000_0004);
        expect_e("rst_valid", 0, S_VALID, 32'h0);
        expect_e("rst_rd1", 0, S_RD1, 32'h0);
        tick();
        chk("rst_lus", 32'(lus[0]), 32'h0);

        // Preload x1..x3; ValidD low gives bubbles that still carry the PC.
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h100);
        wb(1'b1, 5'd1, 32'h1111_1111);
        expect_e("idle_valid", 0, S_VALID, 32'h0);
        expect_e("idle_pce", 0, S_PCE, 32'h100);
        tick();
        wb(1'b1, 5'd2, 32'h2222_2222);
        tick();
        wb(1'b1, 5'd3, 32'h3333_3333);
        tick();

        // Same-cycle write-back of x3 while decoding addi x4,x3,1.
        wb(1'b1, 5'd3, 32'hDEAD_BEEF);
        drive(1'b1, I_ADDI_X4, 32'h200);
        expect_e("byp_rd1", 0, S_RD1, 32'hDEAD_BEEF);
        expect_e("nobyp_rd1", 1, S_RD1, 32'h3333_3333);
        expect_e("byp_rd1", 2, S_RD1, 32'hDEAD_BEEF);
        expect_e("addi_valid", 0, S_VALID, 32'h1);
        expect_e("addi_imm", 0, S_IMM, 32'h1);
        expect_e("addi_alusrc", 0, S_ALUSRC, 32'h1);
        expect_e("addi_rd", 0, S_RDE, 32'd4);
        tick();

        // Load followed by a dependent add.
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, I_LW_X5, 32'h204);
        expect_e("lw_memr", 0, S_MEMR, 32'h1);
        expect_e("lw_rd", 0, S_RDE, 32'd5);
        expect_e("lw_rd1", 0, S_RD1, 32'h1111_1111);
        tick();
        drive(1'b1, I_ADD_X6, 32'h208);
        #1;
        chk("lus_hi[u0]", 32'(lus[0]), 32'h1);
        chk("lus_hi[u2]", 32'(lus[2]), 32'h1);
        expect_e("lus_bub_valid", 0, S_VALID, 32'h0);
        expect_e("lus_bub_regw", 0, S_REGW, 32'h0);
        tick();
        chk("lus_lo[u0]", 32'(lus[0]), 32'h0);
        expect_e("add_valid", 0, S_VALID, 32'h1);
        expect_e("add_rs1", 0, S_RS1, 32'd5);
        expect_e("add_rd", 0, S_RDE, 32'd6);
        expect_e("add_regw", 0, S_REGW, 32'h1);
        expect_e("add_rd2", 0, S_RD2, 32'h2222_2222);
        tick();

        // Flush and stall together: flush wins.
        FlushE = 1'b1; StallE = 1'b1;
        expect_e("flush_valid", 0, S_VALID, 32'h0);
        expect_e("flush_ctrl", 0, S_CTRL, 32'h0);
        expect_e("flush_rs1", 0, S_RS1, 32'h0);
        tick();
        FlushE = 1'b0; StallE = 1'b0;

        // Store with negative offset.
        drive(1'b1, I_SW, 32'h300);
        expect_e("sw_imm", 0, S_IMM, 32'hFFFF_FFFC);
        expect_e("sw_memw", 0, S_MEMW, 32'h1);
        expect_e("sw_alusrc", 0, S_ALUSRC, 32'h1);
        expect_e("sw_regw", 0, S_REGW, 32'h0);
        expect_e("sw_rd2", 0, S_RD2, 32'h2222_2222);
        expect_e("sw_pce", 0, S_PCE, 32'h300);
        tick();

        // Stall alone holds everything despite a new D instruction.
        StallE = 1'b1;
        drive(1'b1, I_ADD_X0, 32'h400);
        expect_e("stall_imm", 0, S_IMM, 32'hFFFF_FFFC);
        expect_e("stall_memw", 0, S_MEMW, 32'h1);
        expect_e("stall_pce", 0, S_PCE, 32'h300);
        expect_e("stall_valid", 0, S_VALID, 32'h1);
        expect_e("stall_rs1", 0, S_RS1, 32'd1);
        tick();
        StallE = 1'b0;

        // Write-back to x0 is ignored, including by the bypass.
        wb(1'b1, 5'd0, 32'h0000_1234);
        expect_e("x0_rd1", 0, S_RD1, 32'h0);
        expect_e("x0_rd2", 0, S_RD2, 32'h0);
        expect_e("x0_rd1", 1, S_RD1, 32'h0);
        expect_e("x0_regw", 0, S_REGW, 32'h1);
        expect_e("x0_rd", 0, S_RDE, 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        expect_e("x0_after_rd1", 1, S_RD1, 32'h0);
        expect_e("x0_after_rd2", 0, S_RD2, 32'h0);
        tick();

        // rd = x17 is illegal only on RV32E; write to x20 must not alias x4.
        wb(1'b1, 5'd20, 32'h5555_5555);
        drive(1'b1, I_ADD_X17, 32'h500);
        expect_e("rv32e_ill", 2, S_ILL, 32'h1);
        expect_e("rv32e_regw", 2, S_REGW, 32'h0);
        expect_e("rv32e_valid", 2, S_VALID, 32'h1);
        expect_e("rv32e_rd1", 2, S_RD1, 32'h1111_1111);
        expect_e("rv32i_ill", 0, S_ILL, 32'h0);
        expect_e("rv32i_regw", 0, S_REGW, 32'h1);
        expect_e("rv32i_rd", 0, S_RDE, 32'd17);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, I_ADD_X4, 32'h504);
        expect_e("x4_untouched", 2, S_RD1, 32'h0);
        expect_e("x4_untouched", 0, S_RD1, 32'h0);
        tick();

        // Mid-stream reset discards E and clears the register file.
        rst = 1'b1;
        drive(1'b1, I_ADD_X6, 32'h600);
        expect_e("mrst_pce", 0, S_PCE, 32'h8000_0000);
        expect_e("mrst_pc4", 0, S_PC4, 32'h8000_0004);
        expect_e("mrst_valid", 0, S_VALID, 32'h0);
        expect_e("mrst_regw", 0, S_REGW, 32'h0);
        expect_e("mrst_valid", 1, S_VALID, 32'h0);
        tick();
        rst = 1'b0;
        ValidD = 1'b1; InstrD = I_ADDI_X4; PCD = 32'hFFFF_FFFC; PCPlus4D = 32'h0;
        expect_e("clr_rd1", 0, S_RD1, 32'h0);
        expect_e("clr_rd1", 1, S_RD1, 32'h0);
        expect_e("clr_valid", 0, S_VALID, 32'h1);
        expect_e("wrap_pce", 0, S_PCE, 32'hFFFF_FFFC);
        expect_e("wrap_pc4", 0, S_PC4, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised decode stage and ID/EX pipeline register for the RV32I/RV32E core. It sits between the fetch/decode register and the execute stage, and contains five functions:
- instruction decode;
- the register file, with write-back bypass;
- immediate generation;
- load-use hazard detection;
- the ID/EX register, with hold, flush and valid tracking.

Compared with the current decode stage, it adds the XLEN, NREGS, BYPASS_WB and reset-PC parameters, bubble insertion, a per-stage valid bit and an illegal-instruction flag.

## Interface
Parameters:
- XLEN, 32: datapath, PC and immediate width. Instructions are always 32 bits. Immediates are sign-extended to XLEN.
- NREGS, 32: architectural register count. 32 selects RV32I; 16 selects RV32E.
- BYPASS_WB, 1: 1 selects write-through read of the same-cycle write-back. 0 selects a plain array read.
- RESET_PC, 0: reset value of PCE and base for PCPlus4E; both are XLEN wide.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: reset. Synchronous, active-high.
- ValidD, input, 1: InstrD holds a real instruction.
- InstrD, input, 32: instruction in decode.
- PCD, PCPlus4D, input, XLEN: PC of InstrD, and that PC + 4.
- StallE, input, 1: hold the ID/EX register.
- FlushE, input, 1: load a bubble into ID/EX.
- RegWriteW, input, 1: write-back enable.
- RDW, input, 5: write-back destination register.
- ResultW, input, XLEN: write-back data.
- LoadUseStall, output, 1: combinational load-use hazard. Fetch/decode must hold on this signal.
- ValidE, IllegalE, output, 1 each: the E instruction is valid; the E instruction is illegal.
- RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE, JumpE, output, 1 each: control signals for E.
- ALUControlE, output, 4.
- funct3_E, output, 3.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, output, XLEN.
- RS1_E, RS2_E, RD_E, output, 5.

## Operation
- The decoder produces control signals, ImmSrc, uses_rs1, uses_rs2 and illegal from InstrD.
  - uses_rs1 = 0 for LUI, AUIPC and JAL.
  - uses_rs2 = 1 only for R, S and B formats.
  - illegal = 1 for an unknown opcode or funct combination, or for any used rs, or a written rd, with index ≥ NREGS.
  - An illegal instruction loads with every control signal forced to 0 and IllegalE = 1.
- Register file:
  - Holds NREGS × XLEN. x0 always reads as 0.
  - A write occurs at the clock edge when RegWriteW && RDW != 0 && RDW < NREGS.
  - Reads are asynchronous. With BYPASS_WB = 1, a read whose rs matches the active write takes ResultW.
- LoadUseStall = ValidE && MemReadE && RD_E != 0 && ValidD && ((uses_rs1 && rs1 == RD_E) || (uses_rs2 && rs2 == RD_E)).
- ID/EX register update, per clock edge, highest priority first:
  1. rst: all outputs take their reset values.
  2. FlushE: bubble.
  3. StallE: hold all contents.
  4. LoadUseStall: bubble. Fetch/decode hold D, so the instruction re-decodes next cycle.
  5. !ValidD: bubble.
  6. Otherwise: load the decoded instruction. ValidE = 1.
- Bubble contents:
  - ValidE, IllegalE and all control signals are 0.
  - RD_E, RS1_E and RS2_E are 0.
  - Data fields are 0.
  - PCE and PCPlus4E keep PCD and PCPlus4D, for trace only.

## Timing
- Latency: one cycle from D to E.
- LoadUseStall is combinational in the same cycle and has no register.
- Reset values:
  - PCE = RESET_PC; PCPlus4E = RESET_PC + 4.
  - Every other output register is 0.
  - The register file clears to 0 in the same reset cycle.
- Reset mid-operation: any in-flight E instruction is discarded in that cycle.
- Simultaneous events:
  - FlushE with StallE: flush wins.
  - StallE with LoadUseStall: E holds. LoadUseStall stays asserted, so D also holds, and the hazard is resolved on the first non-stalled edge.
  - A write-back and a decode read of the same register in the same cycle: the read returns ResultW when BYPASS_WB = 1, or the old value when BYPASS_WB = 0.
- PC arithmetic wraps modulo 2^XLEN.

## Structure
- Shared package rv_pkg holds the following:
  - opcode constants;
  - ImmSrc encoding, 3 bits: I, S, B, U, J;
  - ALUControl encoding, 4 bits;
  - a bubble-value constant for the control bundle.
- Sub-module decode_ctrl: purely combinational. Outputs the control signals, ImmSrc, uses_rs1, uses_rs2 and illegal.
- The register file, immediate extender and hazard logic are written inline.

## Test plan
- Load-use: `lw x5,0(x1)` followed by `add x6,x5,x2`.
  - LoadUseStall = 1 for exactly one cycle.
  - E then holds a bubble with ValidE = 0 and RegWriteE = 0.
  - On the next cycle, the add loads with RS1_E = 5.
- Bypass: RegWriteW = 1, RDW = 3, ResultW = 0xDEADBEEF while decoding `addi x4,x3,1`.
  - BYPASS_WB = 1: RD1_E = 0xDEADBEEF.
  - BYPASS_WB = 0: RD1_E = the old x3.
- Priority: assert FlushE and StallE together with a valid add in D.
  - ValidE = 0 and all control signals are 0 on the next cycle.
  - With StallE alone, every E output is unchanged.
- RV32E (NREGS = 16): decode `add x17,x1,x2`.
  - IllegalE = 1 and RegWriteE = 0.
  - A write-back to RDW = 20 leaves the register file unchanged.
- x0 and reset:
  - A write-back of 0x1234 to x0, then `add x1,x0,x0`, gives RD1_E = RD2_E = 0.
  - Assert rst mid-stream with RESET_PC = 0x80000000: PCE = 0x80000000, PCPlus4E = 0x80000004, ValidE = 0.
- Immediates: `sw x2,-4(x1)` gives Imm_Ext_E = 0xFFFFFFFC, MemWriteE = 1 and ALUSrcE = 1.
